// File: rtl/onehot_mux_pipe_if.sv
// Handshake bundle for onehot_mux_pipe: parallel producer side and single consumer side.
// slave  = view of the mux stage itself; master = view of the surrounding producer/consumer.
interface onehot_mux_pipe_if #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 2
);
  localparam int unsigned CH_W = $clog2(N);

  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_sel;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    out_data;
  logic [CH_W-1:0] out_ch;
  logic            out_err;
  logic            out_valid;
  logic            out_ready;

  modport slave (
    input  in_data, in_sel, in_valid, out_ready,
    output in_ready, out_data, out_ch, out_err, out_valid
  );

  modport master (
    output in_data, in_sel, in_valid, out_ready,
    input  in_ready, out_data, out_ch, out_err, out_valid
  );
endinterface

// File: rtl/onehot_mux_pipe.sv
// N-channel one-hot mux with a single-entry registered valid/ready output stage
// and a saturating count of accepted illegal (zero or multi-hot) selects.
// Build option ONEHOT_MUX_PRIO_FALLBACK_EN: multi-hot selects take the lowest set
// channel's data; otherwise they take the OR of all selected channels.
module onehot_mux_pipe #(
  parameter int unsigned N     = 4,
  parameter int unsigned W     = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  onehot_mux_pipe_if.slave      io,
  output logic [CNT_W-1:0]      err_cnt,
  input  logic                  err_clr
);
  localparam int unsigned CH_W = $clog2(N);

  logic [W-1:0]     sel_data;
  logic [CH_W-1:0]  sel_ch;
  logic             sel_err;
  logic             in_ready;
  logic             accept;

  logic             out_valid_d, out_valid_q;
  logic [W-1:0]     out_data_d,  out_data_q;
  logic [CH_W-1:0]  out_ch_d,    out_ch_q;
  logic             out_err_d,   out_err_q;
  logic [CNT_W-1:0] err_cnt_d,   err_cnt_q;

  assign in_ready     = !out_valid_q || io.out_ready;
  assign accept       = io.in_valid && in_ready;

  assign io.in_ready  = in_ready;
  assign io.out_valid = out_valid_q;
  assign io.out_data  = out_data_q;
  assign io.out_ch    = out_ch_q;
  assign io.out_err   = out_err_q;
  assign err_cnt      = err_cnt_q;

  // Decode the select: lowest set index, legality, and the selected data.
  always_comb begin
    int unsigned ones;
    logic        found;
    logic [W-1:0] or_data;
`ifdef ONEHOT_MUX_PRIO_FALLBACK_EN
    logic [W-1:0] lo_data;
    lo_data = '0;
`endif
    ones    = 0;
    found   = 1'b0;
    or_data = '0;
    sel_ch  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (io.in_sel[i]) begin
        ones++;
        or_data = or_data | io.in_data[i*W +: W];
        if (!found) begin
          found  = 1'b1;
          sel_ch = CH_W'(i);
`ifdef ONEHOT_MUX_PRIO_FALLBACK_EN
          lo_data = io.in_data[i*W +: W];
`endif
        end
      end
    end
    sel_err = (ones != 1);
`ifdef ONEHOT_MUX_PRIO_FALLBACK_EN
    sel_data = lo_data;
`else
    sel_data = or_data;
`endif
  end

  // Next state of the output register and the error counter.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_err_d   = out_err_q;
    err_cnt_d   = err_cnt_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data;
      out_ch_d    = sel_ch;
      out_err_d   = sel_err;
    end else if (io.out_ready) begin
      out_valid_d = 1'b0;
    end
    if (err_clr) begin
      err_cnt_d = '0;
    end else if (accept && sel_err && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  // Registers with synchronous reset; reset drops any held beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_err_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_err_q   <= out_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end
endmodule

// File: tb/tb_onehot_mux_pipe.sv
// Scoreboard bench for onehot_mux_pipe (N=4, W=2, CNT_W=2).
module tb_onehot_mux_pipe;
  localparam int unsigned N = 4;
  localparam int unsigned W = 2;
  localparam int unsigned CNT_W = 2;

  typedef struct {
    logic [W-1:0] data;
    logic [1:0]   ch;
    logic         err;
    int unsigned  cyc;
  } beat_t;

  logic clk;
  logic rst;
  logic err_clr;
  logic [CNT_W-1:0] err_cnt;

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;
  int unsigned n_acc = 0;
  int unsigned exp_cnt = 0;
  bit lat_chk = 0;
  beat_t q[$];

  onehot_mux_pipe_if #(.N(N), .W(W)) bus ();

  onehot_mux_pipe #(.N(N), .W(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .io(bus), .err_cnt(err_cnt), .err_clr(err_clr)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference: count selected bits; zero -> 0/err, one -> that channel, several -> build option.
  function automatic beat_t model(input logic [7:0] d, input logic [3:0] s);
    beat_t b;
    int n;
    int lo;
    n = $countones(s);
    lo = 0;
    b.data = '0;
    b.ch = '0;
    b.err = (n != 1);
    b.cyc = 0;
    if (n > 0) begin
      for (int i = 3; i >= 0; i--) if (s[i]) lo = i;
      b.ch = 2'(lo);
`ifdef ONEHOT_MUX_PRIO_FALLBACK_EN
      b.data = d[lo*2 +: 2];
`else
      for (int i = 0; i < 4; i++) if (s[i]) b.data = b.data | d[i*2 +: 2];
`endif
    end
    return b;
  endfunction

  task automatic drv(input bit v, input logic [7:0] d, input logic [3:0] s,
                     input bit ordy, input bit clr);
    @(posedge clk);
    #1;
    bus.in_valid = v;
    bus.in_data = d;
    bus.in_sel = s;
    bus.out_ready = ordy;
    err_clr = clr;
  endtask

  // Input side: push expected beats and track the expected error count.
  always @(negedge clk) begin
    beat_t b;
    bit acc;
    if (rst) begin
      q.delete();
      exp_cnt = 0;
    end else begin
      chk("err_cnt", 32'(err_cnt), exp_cnt);
      acc = bus.in_valid && bus.in_ready;
      b = model(bus.in_data, bus.in_sel);
      if (acc) begin
        b.cyc = cyc;
        q.push_back(b);
        n_acc++;
      end
      if (err_clr) exp_cnt = 0;
      else if (acc && b.err && exp_cnt < 3) exp_cnt++;
    end
  end

  // Output side: pop and compare delivered beats; held beats must stay frozen.
  logic [W-1:0] p_data;
  logic [1:0]   p_ch;
  logic         p_err;
  bit           p_stall = 0;
  always @(negedge clk) begin
    beat_t e;
    if (!rst && p_stall) begin
      chk("stall_valid", 32'(bus.out_valid), 1);
      chk("stall_data", 32'(bus.out_data), 32'(p_data));
      chk("stall_ch", 32'(bus.out_ch), 32'(p_ch));
      chk("stall_err", 32'(bus.out_err), 32'(p_err));
    end
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_beat", 1, 0);
      end else begin
        e = q.pop_front();
        chk("out_data", 32'(bus.out_data), 32'(e.data));
        chk("out_ch", 32'(bus.out_ch), 32'(e.ch));
        chk("out_err", 32'(bus.out_err), 32'(e.err));
        if (lat_chk) chk("latency", cyc, e.cyc + 1);
      end
    end
    p_stall = !rst && bus.out_valid && !bus.out_ready;
    p_data = bus.out_data;
    p_ch = bus.out_ch;
    p_err = bus.out_err;
  end

  localparam logic [7:0] DCH = 8'b11_10_01_00;

  initial begin
    int unsigned start;
    int unsigned loops;
    logic [3:0] s;
    rst = 1;
    err_clr = 0;
    bus.in_valid = 0;
    bus.in_data = '0;
    bus.in_sel = '0;
    bus.out_ready = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_data", 32'(bus.out_data), 0);
    chk("rst_ch", 32'(bus.out_ch), 0);
    chk("rst_err", 32'(bus.out_err), 0);
    chk("rst_cnt", 32'(err_cnt), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    drv(0, DCH, 4'b0000, 1, 0);
    rst = 0;

    // Legal sweep, one beat per cycle.
    lat_chk = 1;
    for (int i = 0; i < 4; i++) begin
      s = 4'b0001 << i;
      drv(1, DCH, s, 1, 0);
    end
    drv(0, DCH, 4'b0000, 1, 0);
    drv(0, DCH, 4'b0000, 1, 0);
    @(negedge clk);
    lat_chk = 0;
    chk("sweep_cnt", 32'(err_cnt), 0);

    // Backpressure: 3 stalled cycles after the first beat.
    drv(1, DCH, 4'b0100, 1, 0);
    drv(1, DCH, 4'b1000, 0, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(bus.in_ready), 0);
      chk("bp_data", 32'(bus.out_data), 2);
      chk("bp_ch", 32'(bus.out_ch), 2);
      if (k < 2) @(posedge clk);
    end
    drv(1, DCH, 4'b1000, 1, 0);
    drv(0, DCH, 4'b0000, 1, 0);
    drv(0, DCH, 4'b0000, 1, 0);

    // Illegal selects.
    drv(1, DCH, 4'b0000, 1, 0);
    drv(1, DCH, 4'b1010, 1, 0);
    @(negedge clk);
    chk("zero_data", 32'(bus.out_data), 0);
    chk("zero_ch", 32'(bus.out_ch), 0);
    chk("zero_err", 32'(bus.out_err), 1);
    drv(0, DCH, 4'b0000, 1, 0);
    @(negedge clk);
`ifdef ONEHOT_MUX_PRIO_FALLBACK_EN
    chk("multi_data", 32'(bus.out_data), 1);
`else
    chk("multi_data", 32'(bus.out_data), 3);
`endif
    chk("multi_ch", 32'(bus.out_ch), 1);
    chk("multi_err", 32'(bus.out_err), 1);
    chk("illegal_cnt", 32'(err_cnt), 2);

    // Saturation and clear.
    for (int i = 0; i < 5; i++) drv(1, $urandom, (i % 2 == 0) ? 4'b0000 : 4'b0110, 1, 0);
    drv(0, DCH, 4'b0000, 1, 0);
    @(negedge clk);
    chk("sat_cnt", 32'(err_cnt), 3);
    drv(1, DCH, 4'b0000, 1, 1);
    drv(0, DCH, 4'b0000, 1, 0);
    @(negedge clk);
    chk("clr_cnt", 32'(err_cnt), 0);
    drv(0, DCH, 4'b0000, 1, 0);
    drv(0, DCH, 4'b1100, 1, 0);
    @(negedge clk);
    chk("novalid_cnt", 32'(err_cnt), 0);

    // Reset while a beat is stalled.
    drv(1, DCH, 4'b0000, 0, 0);
    drv(0, DCH, 4'b0000, 0, 0);
    @(negedge clk);
    chk("pre_rst_valid", 32'(bus.out_valid), 1);
    chk("pre_rst_cnt", 32'(err_cnt), 1);
    @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_valid", 32'(bus.out_valid), 0);
    chk("mid_rst_cnt", 32'(err_cnt), 0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 1);
    drv(0, DCH, 4'b0000, 1, 0);
    rst = 0;
    repeat (3) drv(0, DCH, 4'b0000, 1, 0);

    // Random valid/ready with legal selects.
    start = n_acc;
    loops = 0;
    while ((n_acc - start) < 1000 && loops < 20000) begin
      s = 4'b0001 << $urandom_range(0, 3);
      drv(1'($urandom_range(0, 1)), 8'($urandom), s, 1'($urandom_range(0, 1)), 0);
      loops++;
    end
    chk("rand_beats_done", 32'((n_acc - start) >= 1000), 1);
    repeat (3) drv(0, DCH, 4'b0000, 1, 0);
    @(negedge clk);
    chk("rand_cnt", 32'(err_cnt), 0);
    chk("queue_empty", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
